// File: rtl/synth_pkg.sv
// Shared types for the synth sample path: DAC SPI frame layout and writer states.
package synth_pkg;

    localparam int DAC_FRAME_W = 16;
    localparam int DAC_DATA_W  = 12;

    // One MCP4921-class write word, MSB first on the wire.
    typedef struct packed {
        logic                  dac_sel;   // bit15: DAC A(0)/B(1)
        logic                  vref_buf;  // bit14: Vref input buffer
        logic                  ga_n;      // bit13: 1 -> 1x gain
        logic                  shdn_n;    // bit12: 0 -> output shut down
        logic [DAC_DATA_W-1:0] data;      // bits 11..0
    } dac_frame_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        CS_HI,
        LATCH
    } dac_state_t;

    // Assemble the 16-bit command word from the static config bits and the sample.
    function automatic dac_frame_t build_frame(
        input logic                  dac_sel,
        input logic                  vref_buf,
        input logic                  gain_2x,
        input logic                  ena,
        input logic [DAC_DATA_W-1:0] data
    );
        dac_frame_t f;
        f.dac_sel  = dac_sel;
        f.vref_buf = vref_buf;
        f.ga_n     = ~gain_2x;
        f.shdn_n   = ena;
        f.data     = data;
        return f;
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// SCLK phase timer: counts clk cycles and emits tick on the last cycle of each
// CLK_DIV-long phase. Held at zero while clear is asserted.
module dac_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    logic [7:0] count;

    assign tick = (count == 8'(CLK_DIV - 1));

    // Phase counter: wraps on tick so every phase restarts at zero.
    // NOTE: clocked state uses non-blocking (<=) so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/dac_spi_writer.sv
// Serialises 12-bit samples into 16-bit SPI writes for an MCP4921-class DAC.
// Build option DAC_LDAC_SYNC_EN: adds a LATCH phase that pulses ldac_n low after
// each frame; without it ldac_n is held low and the DAC updates on cs_n rise.
module dac_spi_writer
    import synth_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter bit DAC_SEL = 1'b0,
    parameter bit BUF     = 1'b0,
    parameter bit GAIN_2X = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DAC_DATA_W-1:0] sample,
    input  logic                  ena,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    output logic                  ldac_n,
    output logic                  busy
);

`ifdef DAC_LDAC_SYNC_EN
    localparam logic LDAC_IDLE = 1'b1;
`else
    localparam logic LDAC_IDLE = 1'b0;
`endif

    dac_state_t                state, state_nxt;
    dac_frame_t                frame, frame_nxt;
    logic [DAC_FRAME_W-1:0]    frame_bits;
    logic [3:0]                bit_cnt, bit_cnt_nxt;
    logic                      ready_nxt, busy_nxt, cs_n_nxt, sclk_nxt, mosi_nxt, ldac_n_nxt;
    logic                      tick;

    assign frame_bits = frame;

    dac_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(state == IDLE),
        .tick (tick)
    );

    // Next-state and next-output logic; every output is registered below.
    // NOTE: each variable gets its held value first so no branch can infer a latch.
    always_comb begin
        state_nxt   = state;
        frame_nxt   = frame;
        bit_cnt_nxt = bit_cnt;
        ready_nxt   = sample_ready;
        busy_nxt    = busy;
        cs_n_nxt    = cs_n;
        sclk_nxt    = sclk;
        mosi_nxt    = mosi;
        ldac_n_nxt  = ldac_n;

        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
                if (sample_valid && sample_ready) begin
                    frame_nxt = build_frame(DAC_SEL, BUF, GAIN_2X, ena, sample);
                    state_nxt = SETUP;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    cs_n_nxt  = 1'b0;
                    sclk_nxt  = 1'b0;
                    mosi_nxt  = frame_nxt.dac_sel;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_nxt   = SHIFT;
                    sclk_nxt    = 1'b1;
                    bit_cnt_nxt = 4'd15;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk) begin
                        // Falling edge: present the next bit for the following rise.
                        sclk_nxt = 1'b0;
                        if (bit_cnt != 4'd0) begin
                            mosi_nxt = frame_bits[bit_cnt - 4'd1];
                        end
                    end else if (bit_cnt == 4'd0) begin
                        state_nxt = CS_HI;
                        cs_n_nxt  = 1'b1;
                        mosi_nxt  = 1'b0;
                    end else begin
                        sclk_nxt    = 1'b1;
                        bit_cnt_nxt = bit_cnt - 4'd1;
                    end
                end
            end
            CS_HI: begin
                if (tick) begin
`ifdef DAC_LDAC_SYNC_EN
                    state_nxt  = LATCH;
                    ldac_n_nxt = 1'b0;
`else
                    state_nxt  = IDLE;
                    ready_nxt  = 1'b1;
                    busy_nxt   = 1'b0;
`endif
                end
            end
`ifdef DAC_LDAC_SYNC_EN
            LATCH: begin
                if (tick) begin
                    state_nxt  = IDLE;
                    ldac_n_nxt = 1'b1;
                    ready_nxt  = 1'b1;
                    busy_nxt   = 1'b0;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset parks the SPI bus idle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            frame        <= '0;
            bit_cnt      <= '0;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
            cs_n         <= 1'b1;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            ldac_n       <= LDAC_IDLE;
        end else begin
            state        <= state_nxt;
            frame        <= frame_nxt;
            bit_cnt      <= bit_cnt_nxt;
            sample_ready <= ready_nxt;
            busy         <= busy_nxt;
            cs_n         <= cs_n_nxt;
            sclk         <= sclk_nxt;
            mosi         <= mosi_nxt;
            ldac_n       <= ldac_n_nxt;
        end
    end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: three instances (CLK_DIV 2, 1, 255) observed by a
// bus monitor that rebuilds each SPI word from mosi at sclk rises.
module tb_dac_spi_writer;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [11:0]    sample = '0;
    logic           ena = 1'b0;
    logic [N-1:0]   valid_v = '0;
    logic [N-1:0]   ready_v, sclk_v, mosi_v, cs_v, ldac_v, busy_v;

    dac_spi_writer #(.CLK_DIV(2)) u_div2 (
        .clk(clk), .rst(rst), .sample(sample), .ena(ena), .sample_valid(valid_v[0]),
        .sample_ready(ready_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]), .cs_n(cs_v[0]),
        .ldac_n(ldac_v[0]), .busy(busy_v[0]));
    dac_spi_writer #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .sample(sample), .ena(ena), .sample_valid(valid_v[1]),
        .sample_ready(ready_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]), .cs_n(cs_v[1]),
        .ldac_n(ldac_v[1]), .busy(busy_v[1]));
    dac_spi_writer #(.CLK_DIV(255)) u_div255 (
        .clk(clk), .rst(rst), .sample(sample), .ena(ena), .sample_valid(valid_v[2]),
        .sample_ready(ready_v[2]), .sclk(sclk_v[2]), .mosi(mosi_v[2]), .cs_n(cs_v[2]),
        .ldac_n(ldac_v[2]), .busy(busy_v[2]));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int cd_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 255;
        endcase
    endfunction

    // Accept-to-ready length: setup + 32 sclk phases + cs high (+ latch).
    function automatic int frame_len(input int i);
`ifdef DAC_LDAC_SYNC_EN
        return 35 * cd_of(i);
`else
        return 34 * cd_of(i);
`endif
    endfunction

    // Reference word: DAC A, unbuffered, 1x gain, SHDN_n = ena, then the 12-bit code.
    function automatic logic [15:0] model(input logic [11:0] s, input logic e);
        return 16'h2000 | (16'(e) << 12) | 16'(s);
    endfunction

    // ---------------- bus monitor (samples on negedge) ----------------
    bit           mon_en = 1'b0;
    logic [N-1:0] p_sclk, p_cs, p_ldac;
    logic [15:0]  sh [N];
    int           rises [N];
    logic [23:0]  fq [N][$];
    int           hi_run [N], lo_run [N], hi_min [N], hi_max [N], lo_min [N], lo_max [N];
    int           stray [N];
    int           cs_rise_cyc [N], ldac_fall_cyc [N], ldac_rise_cyc [N];
    int           ldac_bad = 0;

    // Rebuild SPI words and measure sclk phase lengths for every instance.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                if (!cs_v[i] && p_cs[i]) begin
                    sh[i] = '0;
                    rises[i] = 0;
                    lo_run[i] = 0;
                end
                if (sclk_v[i] && !p_sclk[i]) begin
                    if (!cs_v[i]) begin
                        sh[i] = {sh[i][14:0], mosi_v[i]};
                        rises[i]++;
                    end else begin
                        stray[i]++;
                    end
                    if (lo_run[i] > 0) begin
                        if (lo_run[i] < lo_min[i]) lo_min[i] = lo_run[i];
                        if (lo_run[i] > lo_max[i]) lo_max[i] = lo_run[i];
                    end
                    lo_run[i] = 0;
                end
                if (!sclk_v[i] && p_sclk[i] && hi_run[i] > 0) begin
                    if (hi_run[i] < hi_min[i]) hi_min[i] = hi_run[i];
                    if (hi_run[i] > hi_max[i]) hi_max[i] = hi_run[i];
                    hi_run[i] = 0;
                end
                if (sclk_v[i]) hi_run[i]++;
                else if (!cs_v[i]) lo_run[i]++;
                if (cs_v[i] && !p_cs[i]) begin
                    fq[i].push_back({8'(rises[i]), sh[i]});
                    cs_rise_cyc[i] = cyc;
                    lo_run[i] = 0;
                end
                if (!ldac_v[i] && p_ldac[i]) ldac_fall_cyc[i] = cyc;
                if (ldac_v[i] && !p_ldac[i]) ldac_rise_cyc[i] = cyc;
`ifndef DAC_LDAC_SYNC_EN
                if (ldac_v[i] !== 1'b0) ldac_bad++;
`endif
            end
            p_sclk = sclk_v;
            p_cs   = cs_v;
            p_ldac = ldac_v;
        end
    end

    task automatic reset_stats();
        for (int i = 0; i < N; i++) begin
            hi_min[i] = 1 << 30; hi_max[i] = 0;
            lo_min[i] = 1 << 30; lo_max[i] = 0;
            hi_run[i] = 0; lo_run[i] = 0; stray[i] = 0;
            fq[i].delete();
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send(input int i, input logic [11:0] s, input logic e, input string tag,
                        output int acc);
        int n = 0;
        @(negedge clk);
        sample = s;
        ena = e;
        valid_v[i] = 1'b1;
        while (ready_v[i] !== 1'b1 && n < frame_len(i) + 100) begin
            @(negedge clk);
            n++;
        end
        if (ready_v[i] !== 1'b1) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        valid_v[i] = 1'b0;
        check({tag, "_busy"}, 32'(busy_v[i]), 32'd1);
    endtask

    task automatic wait_done(input int i, input int acc, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready_v[i] !== 1'b1 && n < frame_len(i) + 100);
        check({tag, "_len"}, 32'(cyc - acc), 32'(frame_len(i)));
    endtask

    task automatic pop_frame(input int i, input logic [15:0] exp, input string tag);
        logic [23:0] got;
        if (fq[i].size() == 0) begin
            check({tag, "_frame_missing"}, 32'd0, 32'd1);
        end else begin
            got = fq[i].pop_front();
            check({tag, "_frame"}, 32'(got[15:0]), 32'(exp));
            check({tag, "_rises"}, 32'(got[23:16]), 32'd16);
        end
    endtask

    task automatic run_frame(input int i, input logic [11:0] s, input logic e,
                             input logic [15:0] exp, input string tag);
        int acc;
        send(i, s, e, tag, acc);
        wait_done(i, acc, tag);
        pop_frame(i, exp, tag);
`ifdef DAC_LDAC_SYNC_EN
        check({tag, "_ldac_delay"}, 32'(ldac_fall_cyc[i] - cs_rise_cyc[i]), 32'(cd_of(i)));
        check({tag, "_ldac_width"}, 32'(ldac_rise_cyc[i] - ldac_fall_cyc[i]), 32'(cd_of(i)));
`endif
    endtask

    typedef struct {
        logic [11:0] smp;
        logic        en;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs [6];
    int          acc, acc1, acc2, n;
    logic [11:0] rs;
    logic        re;

    initial begin
        vecs[0] = '{12'hA5C, 1'b1, 16'h3A5C};
        vecs[1] = '{12'h000, 1'b0, 16'h2000};
        vecs[2] = '{12'h001, 1'b1, 16'h3001};
        vecs[3] = '{12'hFFF, 1'b1, 16'h3FFF};
        vecs[4] = '{12'h800, 1'b0, 16'h2800};
        vecs[5] = '{12'h7FF, 1'b1, 16'h37FF};
        reset_stats();

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_v), 32'b111);
        check("rst_sclk", 32'(sclk_v), 32'b000);
        check("rst_mosi", 32'(mosi_v), 32'b000);
        check("rst_ready", 32'(ready_v), 32'b000);
        check("rst_busy", 32'(busy_v), 32'b000);
`ifdef DAC_LDAC_SYNC_EN
        check("rst_ldac", 32'(ldac_v), 32'b111);
`else
        check("rst_ldac", 32'(ldac_v), 32'b000);
`endif
        p_sclk = sclk_v; p_cs = cs_v; p_ldac = ldac_v;
        mon_en = 1'b1;
        rst = 1'b1;
        #1 check("release_ready_pre_edge", 32'(ready_v), 32'b000);
        @(posedge clk);
        #1 check("release_ready", 32'(ready_v), 32'b111);

        // Reset in the middle of SHIFT: bus idles at once, frame is dropped.
        send(0, 12'hA5C, 1'b1, "rstmid", acc);
        repeat (20) @(negedge clk);
        check("rstmid_active", 32'(cs_v[0]), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rstmid_cs_n", 32'(cs_v[0]), 32'd1);
        check("rstmid_sclk", 32'(sclk_v[0]), 32'd0);
        check("rstmid_ready", 32'(ready_v[0]), 32'd0);
        check("rstmid_busy", 32'(busy_v[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check("rstmid_ready_after", 32'(ready_v[0]), 32'd1);
        repeat (10) @(negedge clk);
        check("rstmid_no_resume_cs", 32'(cs_v[0]), 32'd1);
        check("rstmid_no_resume_busy", 32'(busy_v[0]), 32'd0);
        #1 reset_stats();

        // Table vectors on the CLK_DIV=2 instance.
        for (int k = 0; k < 6; k++)
            run_frame(0, vecs[k].smp, vecs[k].en, vecs[k].exp, $sformatf("vec%0d", k));

        // Inputs changed mid-frame must not alter the word in flight.
        send(0, 12'h000, 1'b0, "hold", acc);
        repeat (30) @(negedge clk);
        sample = 12'hFFF;
        ena = 1'b1;
        wait_done(0, acc, "hold");
        pop_frame(0, 16'h2000, "hold");

        // Valid held high across two samples: no loss, next accept on first idle cycle.
        @(negedge clk);
        sample = 12'h001; ena = 1'b1; valid_v[0] = 1'b1;
        n = 0;
        while (ready_v[0] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 acc1 = cyc;
        sample = 12'hFFF;
        n = 0;
        do begin @(negedge clk); n++; end while (ready_v[0] !== 1'b1 && n < 200);
        @(posedge clk);
        #1 acc2 = cyc;
        valid_v[0] = 1'b0;
        check("b2b_gap", 32'(acc2 - acc1), 32'(frame_len(0) + 1));
        check("b2b_busy2", 32'(busy_v[0]), 32'd1);
        wait_done(0, acc2, "b2b2");
        pop_frame(0, 16'h3001, "b2b1");
        pop_frame(0, 16'h3FFF, "b2b2");
        repeat (5) @(negedge clk);
        check("b2b_no_extra", 32'(fq[0].size()), 32'd0);

        // Random samples against the reference word.
        for (int k = 0; k < 10; k++) begin
            rs = 12'($urandom_range(0, 4095));
            re = 1'($urandom_range(0, 1));
            run_frame(0, rs, re, model(rs, re), $sformatf("rnd%0d", k));
        end

        // Divider extremes.
        run_frame(1, 12'hA5C, 1'b1, 16'h3A5C, "div1_a");
        rs = 12'($urandom_range(0, 4095));
        run_frame(1, rs, 1'b0, model(rs, 1'b0), "div1_b");
        run_frame(2, 12'h5A3, 1'b1, model(12'h5A3, 1'b1), "div255");

        // Half-period, stray-clock and ldac summaries.
        for (int i = 0; i < N; i++) begin
            check($sformatf("hi_min_%0d", i), 32'(hi_min[i]), 32'(cd_of(i)));
            check($sformatf("hi_max_%0d", i), 32'(hi_max[i]), 32'(cd_of(i)));
            check($sformatf("lo_min_%0d", i), 32'(lo_min[i]), 32'(cd_of(i)));
            check($sformatf("lo_max_%0d", i), 32'(lo_max[i]), 32'(cd_of(i)));
            check($sformatf("stray_sclk_%0d", i), 32'(stray[i]), 32'd0);
        end
`ifndef DAC_LDAC_SYNC_EN
        check("ldac_const_low", 32'(ldac_bad), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
